// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for the RV64 core. Owns the program counter, issues
// one 32-bit instruction read at a time to instruction memory, buffers the
// returned words with their PCs in a 2-entry FIFO and hands them to the
// decoder. A redirect from the back end flushes the FIFO and any fetch still
// in flight, then restarts fetching at the new PC.
//
// Parameters
//   RESET_PC        PC of the first fetch after reset.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous, active-high reset
//   redirect_valid  one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc     new fetch PC, bits [1:0] ignored
//   mem_req_valid   fetch request valid
//   mem_req_addr    fetch address, 4-byte aligned
//   mem_req_ready   memory accepts the request this cycle
//   mem_resp_valid  read data valid (one per accepted request, in order)
//   mem_resp_data   instruction word returned by memory
//   instr_valid     FIFO head valid, to the decoder
//   instr           instruction word at the FIFO head
//   instr_pc        PC of instr
//   instr_ready     decoder consumes the head this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // may issue a request
    ST_WAIT  = 2'd1,  // one request outstanding, response will be kept
    ST_DRAIN = 2'd2   // one stale request outstanding, response is dropped
  } state_e;

  localparam int unsigned DEPTH = 2;

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;

  logic [63:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_data_q [DEPTH];

  logic        req_valid;
  logic        req_accept;
  logic        push;
  logic        pop;
  logic        flush;
  logic        head_valid;

  // The two low redirect bits are deliberately dropped to keep fetches aligned.
  logic        redirect_pc_unused;
  assign redirect_pc_unused = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Output decode. Everything visible is forced to zero while reset is high so
  // downstream logic never sees RESET_PC or stale FIFO contents mid-reset.
  // ---------------------------------------------------------------------------
  assign req_valid     = (state_q == ST_FETCH) && (count_q < 2'd2);
  assign mem_req_valid = req_valid && !reset;
  assign mem_req_addr  = reset ? 64'h0 : fetch_pc_q;
  assign req_accept    = mem_req_valid && mem_req_ready;

  assign head_valid    = (count_q != 2'd0) && !reset;
  assign instr_valid   = head_valid;
  assign instr         = head_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign instr_pc      = head_valid ? fifo_pc_q[rd_ptr_q]   : 64'h0;

  assign pop           = head_valid && instr_ready;
  assign flush         = redirect_valid;

  // ---------------------------------------------------------------------------
  // Next-state logic for the fetch FSM and program counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    push          = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        // A response here is a protocol violation and is ignored.
        if (req_accept) begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 64'd4;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Space is guaranteed: a request only issues when count < 2.
        if (mem_resp_valid) begin
          push    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (mem_resp_valid) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Redirect overrides everything. If a request is still outstanding after
    // this cycle, its response must be swallowed in DRAIN; a response that
    // lands in the redirect cycle itself is simply dropped.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      push       = 1'b0;
      if (((state_q == ST_WAIT)  && !mem_resp_valid) ||
          ((state_q == ST_FETCH) && req_accept)      ||
          ((state_q == ST_DRAIN) && !mem_resp_valid)) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FETCH;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO occupancy and pointers. A pop in the flush cycle still delivers the
  // head to the decoder; the flush then discards whatever remains.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= 64'h0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage. Entries carry no reset: they are only observable through
  // instr/instr_pc, which are masked whenever the FIFO is empty.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!reset && push && (wr_ptr_q == 1'(gi))) begin
        fifo_pc_q[gi]   <= inflight_pc_q;
        fifo_data_q[gi] <= mem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small memory model answers each accepted
// request a fixed number of cycles later; requests issued and instructions
// delivered to the decoder are logged and compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;

  int          vectors;
  int          miscompares;

  // memory model state
  int          lat;
  bit          tag_en;
  int          pend;
  logic [63:0] pend_addr;

  logic [63:0] req_q[$];
  logic [63:0] dec_pc_q[$];
  logic [31:0] dec_dat_q[$];

  fetch_unit #(.RESET_PC(64'h1000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Handshakes are sampled just before the edge, the
  // memory response for the next cycle is driven just after it.
  task automatic tick();
    logic acc;
    #2;
    acc = mem_req_valid && mem_req_ready;
    if (acc) begin
      req_q.push_back(mem_req_addr);
      pend_addr = mem_req_addr;
    end
    if (instr_valid && instr_ready) begin
      dec_pc_q.push_back(instr_pc);
      dec_dat_q.push_back(instr);
    end
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    if (acc) pend = lat;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = tag_en ? {pend_addr[19:0], 12'h013} : 32'h00000013;
      end
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    repeat (4) tick();
    pend           = 0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    req_q.delete();
    dec_pc_q.delete();
    dec_dat_q.delete();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_dec(input int n, input string tag);
    for (int i = 0; i < 40 && dec_pc_q.size() < n; i++) tick();
    check(tag, 64'(dec_pc_q.size()), 64'(n));
  endtask

  task automatic wait_req(input int n, input string tag);
    for (int i = 0; i < 40 && req_q.size() < n; i++) tick();
    check(tag, 64'(req_q.size()), 64'(n));
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    instr_ready    = 1'b1;
    lat            = 1;
    tag_en         = 1'b0;
    pend           = 0;
    pend_addr      = 64'h0;

    // ---- reset values ----
    tick();
    tick();
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_addr",  mem_req_addr,       64'h0);
    check("rst_instr_vld", 64'(instr_valid),   64'd0);
    check("rst_instr",     64'(instr),         64'h0);
    check("rst_instr_pc",  instr_pc,           64'h0);

    // ---- straight-line fetch, 1-cycle memory ----
    reset = 1'b0;
    #1;
    check("c0_req_valid", 64'(mem_req_valid), 64'd1);
    check("c0_req_addr",  mem_req_addr,       64'h1000);
    tick();
    check("c1_wait_noreq", 64'(mem_req_valid), 64'd0);
    check("c1_instr_vld",  64'(instr_valid),   64'd0);
    tick();
    check("c2_instr_vld",  64'(instr_valid),   64'd1);
    check("c2_instr_pc",   instr_pc,           64'h1000);
    check("c2_instr",      64'(instr),         64'h13);
    check("c2_req_addr",   mem_req_addr,       64'h1004);
    wait_dec(3, "seq_dec_count");
    check("seq_req0", req_q[0], 64'h1000);
    check("seq_req1", req_q[1], 64'h1004);
    check("seq_req2", req_q[2], 64'h1008);
    for (int i = 0; i < 3; i++) begin
      check("seq_dec_pc",  dec_pc_q[i],       64'h1000 + 64'(4 * i));
      check("seq_dec_dat", 64'(dec_dat_q[i]), 64'h13);
    end

    // ---- backpressure ----
    do_reset();
    tag_en      = 1'b1;
    instr_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 4) check("bp_noreq", 64'(mem_req_valid), 64'd0);
    end
    check("bp_req_count", 64'(req_q.size()), 64'd2);
    check("bp_head_vld",  64'(instr_valid),  64'd1);
    check("bp_head_pc",   instr_pc,          64'h1000);
    check("bp_head_dat",  64'(instr),        64'h01000013);
    instr_ready = 1'b1;
    tick();
    check("bp_next_pc",    instr_pc,           64'h1004);
    check("bp_next_dat",   64'(instr),         64'h01004013);
    check("bp_resume_vld", 64'(mem_req_valid), 64'd1);
    check("bp_resume_adr", mem_req_addr,       64'h1008);
    wait_dec(3, "bp_dec_count");
    check("bp_dec0", dec_pc_q[0], 64'h1000);
    check("bp_dec1", dec_pc_q[1], 64'h1004);
    check("bp_dec2", dec_pc_q[2], 64'h1008);

    // ---- redirect while WAIT, 3-cycle memory ----
    do_reset();
    lat         = 3;
    instr_ready = 1'b0;
    wait_req(2, "rw_req_count");
    check("rw_head_vld", 64'(instr_valid), 64'd1);
    check("rw_head_pc",  instr_pc,         64'h1000);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2002;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    check("rw_flushed",  64'(instr_valid),   64'd0);
    check("rw_drain0",   64'(mem_req_valid), 64'd0);
    tick();
    check("rw_drain1",   64'(mem_req_valid), 64'd0);
    tick();
    check("rw_new_vld",  64'(mem_req_valid), 64'd1);
    check("rw_new_addr", mem_req_addr,       64'h2000);
    wait_dec(1, "rw_dec_count");
    check("rw_dec_pc",  dec_pc_q[0],       64'h2000);
    check("rw_dec_dat", 64'(dec_dat_q[0]), 64'h02000013);

    // ---- redirect in the same cycle as a response ----
    do_reset();
    lat = 1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3001;
    tick();
    redirect_valid = 1'b0;
    check("rr_req_vld",   64'(mem_req_valid), 64'd1);
    check("rr_req_addr",  mem_req_addr,       64'h3000);
    check("rr_instr_vld", 64'(instr_valid),   64'd0);
    tick();
    check("rr_wait",      64'(mem_req_valid), 64'd0);
    tick();
    check("rr_dec_vld",   64'(instr_valid),   64'd1);
    check("rr_dec_pc",    instr_pc,           64'h3000);
    check("rr_dec_dat",   64'(instr),         64'h03000013);

    // ---- redirect with request accepted same cycle, PC wrap ----
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wr_drain",     64'(mem_req_valid), 64'd0);
    check("wr_flush_vld", 64'(instr_valid),   64'd0);
    tick();
    check("wr_req_vld",   64'(mem_req_valid), 64'd1);
    check("wr_req_addr",  mem_req_addr,       64'hFFFF_FFFF_FFFF_FFFC);
    wait_req(3, "wr_req_count");
    check("wr_req1", req_q[1], 64'hFFFF_FFFF_FFFF_FFFC);
    check("wr_req2", req_q[2], 64'h0);
    wait_dec(2, "wr_dec_count");
    check("wr_dec0_pc",  dec_pc_q[0],       64'hFFFF_FFFF_FFFF_FFFC);
    check("wr_dec0_dat", 64'(dec_dat_q[0]), 64'hFFFFC013);
    check("wr_dec1_pc",  dec_pc_q[1],       64'h0);
    check("wr_dec1_dat", 64'(dec_dat_q[1]), 64'h00000013);

    // ---- reset mid-WAIT with one buffered entry ----
    do_reset();
    lat         = 3;
    instr_ready = 1'b0;
    wait_req(2, "mr_req_count");
    check("mr_head_vld", 64'(instr_valid), 64'd1);
    check("mr_head_pc",  instr_pc,         64'h1000);
    reset = 1'b1;
    tick();
    check("mr_req_vld",   64'(mem_req_valid), 64'd0);
    check("mr_req_addr",  mem_req_addr,       64'h0);
    check("mr_instr_vld", 64'(instr_valid),   64'd0);
    check("mr_instr",     64'(instr),         64'h0);
    check("mr_instr_pc",  instr_pc,           64'h0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("mr_rel_vld",   64'(mem_req_valid), 64'd1);
    check("mr_rel_addr",  mem_req_addr,       64'h1000);
    check("mr_rel_empty", 64'(instr_valid),   64'd0);
    instr_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
